// File: rtl/ram_seq_init_ctrl.sv
// Write-side init controller for the multi-port RAM: sweeps every entry with zero/sequential data after
// reset, reconfiguration or power gating, then hands the write ports to the client lanes.
module ram_seq_init_lane #(
    parameter int DEPTH     = 64,
    parameter int INDEX     = 6,
    parameter int WIDTH     = 32,
    parameter int LANE      = 0,
    parameter bit INIT_EN   = 1'b1,
    parameter int RESET_SEQ = 0,
    parameter int SEQ_START = 0
) (
    input  logic             init_act,
    input  logic             pass_act,
    input  logic [INDEX:0]   init_ptr,
    input  logic [INDEX-1:0] cli_addr,
    input  logic [WIDTH-1:0] cli_data,
    input  logic             cli_en,
    output logic [INDEX-1:0] addr,
    output logic [WIDTH-1:0] data,
    output logic             en
);
    localparam logic [WIDTH-1:0] SEQ_BASE = WIDTH'(SEQ_START);

    // One extra bit so the last partial beat can run past DEPTH without wrapping back into range.
    logic [INDEX+1:0] lane_addr;
    logic             hit;

    assign lane_addr = {1'b0, init_ptr} + (INDEX+2)'(LANE);
    assign hit       = INIT_EN && init_act && (lane_addr < (INDEX+2)'(DEPTH));

    always_comb begin
        addr = '0;
        data = '0;
        en   = 1'b0;
        if (pass_act) begin
            addr = cli_addr;
            data = cli_data;
            en   = cli_en;
        end else if (hit) begin
            addr = lane_addr[INDEX-1:0];
            data = (RESET_SEQ != 0) ? SEQ_BASE + WIDTH'(lane_addr) : '0;
            en   = 1'b1;
        end
    end
endmodule

module ram_seq_init_ctrl #(
    parameter int DEPTH        = 64,
    parameter int INDEX        = 6,
    parameter int WIDTH        = 32,
    parameter int NUM_WR_PORTS = 4,
    parameter int INIT_LANES   = 4,
    parameter int RESET_SEQ    = 0,
    parameter int SEQ_START    = 0
) (
    input  logic                            clkGated,
    input  logic                            reset,
    input  logic                            ramGated_i,
    input  logic                            reinitReq_i,
    input  logic [NUM_WR_PORTS*INDEX-1:0]   cliAddrWr_i,
    input  logic [NUM_WR_PORTS*WIDTH-1:0]   cliDataWr_i,
    input  logic [NUM_WR_PORTS-1:0]         cliWrEn_i,
    output logic                            cliStall_o,
    output logic [NUM_WR_PORTS*INDEX-1:0]   ramAddrWr_o,
    output logic [NUM_WR_PORTS*WIDTH-1:0]   ramDataWr_o,
    output logic [NUM_WR_PORTS-1:0]         ramWrEn_o,
    output logic                            ramReady_o,
    output logic                            initDone_o
);
    typedef enum logic [1:0] {INIT, READY, GATED} state_t;

    state_t           state;
    logic [INDEX:0]   init_ptr;
    logic             ready_q;
    logic             done_q;
    logic [INDEX+1:0] ptr_next;
    logic             last_beat;

    assign ptr_next  = {1'b0, init_ptr} + (INDEX+2)'(INIT_LANES);
    assign last_beat = ptr_next >= (INDEX+2)'(DEPTH);

    // Gating wins over reinit; leaving GATED always restarts a full pass regardless of reinitReq_i.
    always_ff @(posedge clkGated) begin
        if (reset) begin
            state    <= INIT;
            init_ptr <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ramGated_i) begin
                state   <= GATED;
                ready_q <= 1'b0;
            end else if (state == GATED || reinitReq_i) begin
                state    <= INIT;
                init_ptr <= '0;
                ready_q  <= 1'b0;
            end else if (state == INIT) begin
                init_ptr <= ptr_next[INDEX:0];
                if (last_beat) begin
                    state   <= READY;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    logic init_act;
    logic pass_act;

    assign init_act   = !reset && (state == INIT);
    assign pass_act   = !reset && (state == READY);
    assign cliStall_o = !pass_act;
    assign ramReady_o = ready_q && !reset;
    assign initDone_o = done_q && !reset;

    for (genvar k = 0; k < NUM_WR_PORTS; k++) begin : g_lane
        ram_seq_init_lane #(
            .DEPTH    (DEPTH),
            .INDEX    (INDEX),
            .WIDTH    (WIDTH),
            .LANE     (k),
            .INIT_EN  (k < INIT_LANES),
            .RESET_SEQ(RESET_SEQ),
            .SEQ_START(SEQ_START)
        ) u_lane (
            .init_act(init_act),
            .pass_act(pass_act),
            .init_ptr(init_ptr),
            .cli_addr(cliAddrWr_i[k*INDEX +: INDEX]),
            .cli_data(cliDataWr_i[k*WIDTH +: WIDTH]),
            .cli_en  (cliWrEn_i[k]),
            .addr    (ramAddrWr_o[k*INDEX +: INDEX]),
            .data    (ramDataWr_o[k*WIDTH +: WIDTH]),
            .en      (ramWrEn_o[k])
        );
    end
endmodule

// File: tb/tb_ram_seq_init_ctrl.sv
// Directed bench for ram_seq_init_ctrl: per-cycle expected output records are queued by the stimulus
// and checked by an independent negedge monitor, for a 64-entry zero-init DUT and a 34-entry seq DUT.
module tb_ram_seq_init_ctrl;
    typedef struct packed {
        logic [3:0]   en;
        logic [23:0]  addr;
        logic [127:0] data;
        logic         ready;
        logic         done;
        logic         stall;
    } rec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1, r2 = 1'b1, gated = 1'b0, reinit = 1'b0;
    logic [3:0]   cli_en = '0;
    logic [23:0]  cli_addr = '0;
    logic [127:0] cli_data = '0;

    logic         n_reset, n_r2, n_gated, n_reinit;
    logic [3:0]   n_en;
    logic [23:0]  n_addr;
    logic [127:0] n_data;

    logic [3:0]   o1_en, o2_en;
    logic [23:0]  o1_addr, o2_addr;
    logic [127:0] o1_data, o2_data;
    logic         o1_ready, o1_done, o1_stall, o2_ready, o2_done, o2_stall;

    rec_t q1[$], q2[$];
    rec_t a1, e1, a2, e2, RST;
    int   vecs = 0, errs = 0;

    always #5 clk = ~clk;

    ram_seq_init_ctrl #(.DEPTH(64), .INDEX(6), .WIDTH(32), .NUM_WR_PORTS(4), .INIT_LANES(4),
                        .RESET_SEQ(0), .SEQ_START(0)) dut1 (
        .clkGated(clk), .reset(reset), .ramGated_i(gated), .reinitReq_i(reinit),
        .cliAddrWr_i(cli_addr), .cliDataWr_i(cli_data), .cliWrEn_i(cli_en),
        .cliStall_o(o1_stall), .ramAddrWr_o(o1_addr), .ramDataWr_o(o1_data), .ramWrEn_o(o1_en),
        .ramReady_o(o1_ready), .initDone_o(o1_done));

    ram_seq_init_ctrl #(.DEPTH(34), .INDEX(6), .WIDTH(32), .NUM_WR_PORTS(4), .INIT_LANES(4),
                        .RESET_SEQ(1), .SEQ_START(32)) dut2 (
        .clkGated(clk), .reset(r2), .ramGated_i(gated), .reinitReq_i(reinit),
        .cliAddrWr_i(cli_addr), .cliDataWr_i(cli_data), .cliWrEn_i(cli_en),
        .cliStall_o(o2_stall), .ramAddrWr_o(o2_addr), .ramDataWr_o(o2_data), .ramWrEn_o(o2_en),
        .ramReady_o(o2_ready), .initDone_o(o2_done));

    function automatic rec_t rec_init(input int ptr, input int depth, input int seq, input int start);
        rec_t r = '0;
        r.stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int a = ptr + k;
            if (a < depth) begin
                r.en[k]           = 1'b1;
                r.addr[k*6 +: 6]  = 6'(a);
                r.data[k*32 +: 32] = (seq != 0) ? 32'(start + a) : 32'd0;
            end
        end
        return r;
    endfunction

    function automatic rec_t rec_ready(input logic done, input logic [3:0] en,
                                       input logic [23:0] addr, input logic [127:0] data);
        rec_t r = '0;
        r.en = en; r.addr = addr; r.data = data;
        r.ready = 1'b1; r.done = done; r.stall = 1'b0;
        return r;
    endfunction

    task automatic step(input rec_t x1, input rec_t x2);
        @(posedge clk); #1;
        reset = n_reset; r2 = n_r2; gated = n_gated; reinit = n_reinit;
        cli_en = n_en; cli_addr = n_addr; cli_data = n_data;
        q1.push_back(x1);
        q2.push_back(x2);
    endtask

    task automatic cli_off();
        n_en = '0; n_addr = '0; n_data = '0;
    endtask

    task automatic cli_a();
        n_en   = 4'b1010;
        n_addr = {6'd9, 6'd0, 6'd5, 6'd0};
        n_data = {32'h12345678, 32'h0, 32'hA5A5A5A5, 32'h0};
    endtask

    task automatic full_pass();
        for (int i = 0; i < 16; i++) step(rec_init(4*i, 64, 0, 0), RST);
        step(rec_ready(1'b1, '0, '0, '0), RST);
        step(rec_ready(1'b0, '0, '0, '0), RST);
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            a1 = {o1_en, o1_addr, o1_data, o1_ready, o1_done, o1_stall};
            vecs++;
            if (a1 !== e1) begin
                errs++;
                $display("FAIL dut1 vec %0d: got %h want %h", vecs, a1, e1);
            end
        end
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            a2 = {o2_en, o2_addr, o2_data, o2_ready, o2_done, o2_stall};
            vecs++;
            if (a2 !== e2) begin
                errs++;
                $display("FAIL dut2 vec %0d: got %h want %h", vecs, a2, e2);
            end
        end
    end

    initial begin
        RST = '0; RST.stall = 1'b1;
        n_reset = 1'b1; n_r2 = 1'b1; n_gated = 1'b0; n_reinit = 1'b0;
        cli_off();
        repeat (3) step(RST, RST);

        // Seq init on the 34-entry DUT: 9 beats, last one only lanes 0,1.
        n_r2 = 1'b0;
        for (int i = 0; i < 9; i++) step(RST, rec_init(4*i, 34, 1, 32));
        step(RST, rec_ready(1'b1, '0, '0, '0));
        step(RST, rec_ready(1'b0, '0, '0, '0));
        n_r2 = 1'b1;
        step(RST, RST);

        // Zero init pass with client writes dropped during beats 3 and 4.
        n_reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 4) cli_a(); else cli_off();
            step(rec_init(4*i, 64, 0, 0), RST);
        end
        cli_off();
        step(rec_ready(1'b1, '0, '0, '0), RST);
        cli_a();
        step(rec_ready(1'b0, 4'b1010, {6'd9, 6'd0, 6'd5, 6'd0},
                       {32'h12345678, 32'h0, 32'hA5A5A5A5, 32'h0}), RST);
        n_en = 4'b1111; n_addr = {6'd2, 6'd1, 6'd0, 6'd63};
        n_data = {32'hFFFFFFFF, 32'h1, 32'h80000000, 32'hDEADBEEF};
        step(rec_ready(1'b0, 4'b1111, {6'd2, 6'd1, 6'd0, 6'd63},
                       {32'hFFFFFFFF, 32'h1, 32'h80000000, 32'hDEADBEEF}), RST);

        // Reinit in READY (same-cycle write passes), then again mid-pass at beat 7.
        cli_a(); n_reinit = 1'b1;
        step(rec_ready(1'b0, 4'b1010, {6'd9, 6'd0, 6'd5, 6'd0},
                       {32'h12345678, 32'h0, 32'hA5A5A5A5, 32'h0}), RST);
        cli_off(); n_reinit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_reinit = (i == 7);
            step(rec_init(4*i, 64, 0, 0), RST);
        end
        n_reinit = 1'b0;
        full_pass();

        // Gated for 5 cycles from READY, reinit and client writes must be ignored.
        n_gated = 1'b1;
        step(rec_ready(1'b0, '0, '0, '0), RST);
        cli_a(); n_reinit = 1'b1;
        repeat (4) step(RST, RST);
        cli_off(); n_gated = 1'b0; n_reinit = 1'b0;
        step(RST, RST);
        full_pass();

        // Reset at beat 10 of a pass restarts from address 0.
        n_reinit = 1'b1;
        step(rec_ready(1'b0, '0, '0, '0), RST);
        n_reinit = 1'b0;
        for (int i = 0; i < 10; i++) step(rec_init(4*i, 64, 0, 0), RST);
        n_reset = 1'b1; cli_a();
        repeat (2) step(RST, RST);
        n_reset = 1'b0; cli_off();
        full_pass();

        @(posedge clk); @(negedge clk); #1;
        vecs++;
        if (q1.size() + q2.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending want 0", q1.size() + q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
